// File: rtl/apb_timer_array_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer_array_if
// Brief    : APB slave bus bundle for apb_timer_array (master/slave modports).
// Revision : 1.0 - initial release
// ============================================================================
interface apb_timer_array_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] paddr_i;
    logic [31:0]               pwdata_i;
    logic                      pwrite_i;
    logic                      psel_i;
    logic                      penable_i;
    logic [31:0]               prdata_o;
    logic                      pready_o;
    logic                      pslverr_o;

    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        input  prdata_o, pready_o, pslverr_o
    );
endinterface
`default_nettype wire

// File: rtl/apb_timer_array.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer_array
// Brief    : TIM_NUM-channel APB timer, each with prescaler, counter, compare
//            and level IRQ. Optional macro APB_TIMER_CASCADE_EN chains channel
//            i's tick to channel i-1's match event.
// Revision : 1.0 - initial release
// ============================================================================
module apb_timer_array #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIM_NUM        = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int PRESC_WIDTH    = 8
) (
    input  wire                  pclk_i,
    input  wire                  presetn_i,
    apb_timer_array_if.slave     bus,
    output wire [TIM_NUM-1:0]    irq_o
);

    localparam int c_CH_W = (TIM_NUM > 1) ? $clog2(TIM_NUM) : 1;

    wire [c_CH_W-1:0] w_ch     = bus.paddr_i[c_CH_W+3:4];
    wire [1:0]        w_reg    = bus.paddr_i[3:2];
    wire              w_valid  = (int'(w_ch) < TIM_NUM);
    wire              w_access = bus.psel_i & bus.penable_i;
    wire              w_wr     = w_access & bus.pwrite_i & w_valid;

    // Address and data bits outside the decoded fields are don't-care.
    wire              w_unused = ^{bus.paddr_i, bus.pwdata_i};

    wire [TIM_NUM-1:0][31:0] w_rdata_all;
    logic [31:0]             w_rd_sel;

    assign bus.pready_o  = 1'b1;
    assign bus.pslverr_o = w_access & ~w_valid;

    always_comb begin
        w_rd_sel = '0;
        for (int k = 0; k < TIM_NUM; k++) begin
            if (int'(w_ch) == k) w_rd_sel = w_rdata_all[k];
        end
    end

    assign bus.prdata_o = (bus.psel_i && !bus.pwrite_i && w_valid) ? w_rd_sel : '0;

    for (genvar i = 0; i < TIM_NUM; i++) begin : g_ch
        logic                   r_en;
        logic                   r_oneshot;
        logic                   r_ie;
        logic [PRESC_WIDTH-1:0] r_presc;
        logic [PRESC_WIDTH-1:0] r_pcnt;
        logic [CNT_WIDTH-1:0]   r_cnt;
        logic [CNT_WIDTH-1:0]   r_cmp;
        logic                   r_match;

        logic        w_sel;
        logic        w_wr_ctrl;
        logic        w_wr_cnt;
        logic        w_wr_cmp;
        logic        w_wr_stat;
        logic        w_ptick;
        logic        w_tick;
        logic        w_mev;
        logic        w_casc;
        logic [31:0] w_ctrl_rd;
        logic [31:0] w_rdata;

        assign w_sel     = w_wr && (int'(w_ch) == i);
        assign w_wr_ctrl = w_sel && (w_reg == 2'd0);
        assign w_wr_cnt  = w_sel && (w_reg == 2'd1);
        assign w_wr_cmp  = w_sel && (w_reg == 2'd2);
        assign w_wr_stat = w_sel && (w_reg == 2'd3);

        assign w_ptick = r_en && (r_pcnt == r_presc);
        assign w_mev   = w_tick && (r_cnt == r_cmp);

`ifdef APB_TIMER_CASCADE_EN
        if (i > 0) begin : g_casc
            logic r_casc;
            always_ff @(posedge pclk_i or negedge presetn_i) begin
                if (!presetn_i)     r_casc <= 1'b0;
                else if (w_wr_ctrl) r_casc <= bus.pwdata_i[3];
            end
            assign w_casc = r_casc;
            // Cascaded channels count on the previous channel's reload cycle.
            assign w_tick = r_casc ? (r_en && g_ch[i-1].w_mev) : w_ptick;
        end else begin : g_nocasc
            assign w_casc = 1'b0;
            assign w_tick = w_ptick;
        end
`else
        assign w_casc = 1'b0;
        assign w_tick = w_ptick;
`endif

        always_ff @(posedge pclk_i or negedge presetn_i) begin
            if (!presetn_i) begin
                r_en      <= 1'b0;
                r_oneshot <= 1'b0;
                r_ie      <= 1'b0;
                r_presc   <= '0;
                r_pcnt    <= '0;
                r_cnt     <= '0;
                r_cmp     <= '1;
                r_match   <= 1'b0;
            end else begin
                // A CTRL write overrides the one-shot auto-disable.
                if (w_wr_ctrl) begin
                    r_en      <= bus.pwdata_i[0];
                    r_oneshot <= bus.pwdata_i[1];
                    r_ie      <= bus.pwdata_i[2];
                    r_presc   <= bus.pwdata_i[8 +: PRESC_WIDTH];
                end else if (w_mev && r_oneshot) begin
                    r_en <= 1'b0;
                end

                if ((w_wr_ctrl && bus.pwdata_i[0] && !r_en) || !r_en || w_ptick)
                    r_pcnt <= '0;
                else
                    r_pcnt <= r_pcnt + PRESC_WIDTH'(1);

                if (w_wr_cnt)
                    r_cnt <= bus.pwdata_i[CNT_WIDTH-1:0];
                else if (w_tick)
                    r_cnt <= w_mev ? '0 : r_cnt + CNT_WIDTH'(1);

                if (w_wr_cmp)
                    r_cmp <= bus.pwdata_i[CNT_WIDTH-1:0];

                if (w_mev)
                    r_match <= 1'b1;
                else if (w_wr_stat && bus.pwdata_i[0])
                    r_match <= 1'b0;
            end
        end

        assign irq_o[i] = r_match & r_ie;

        assign w_ctrl_rd = {{(24-PRESC_WIDTH){1'b0}}, r_presc, 4'b0000,
                            w_casc, r_ie, r_oneshot, r_en};
        assign w_rdata   = (w_reg == 2'd0) ? w_ctrl_rd      :
                           (w_reg == 2'd1) ? 32'(r_cnt)     :
                           (w_reg == 2'd2) ? 32'(r_cmp)     :
                                             {31'b0, r_match};
        assign w_rdata_all[i] = w_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_timer_array
// Brief    : Directed self-checking bench for apb_timer_array (TIM_NUM=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_timer_array;

    localparam int TIM_NUM = 3;

    logic               pclk    = 1'b0;
    logic               presetn = 1'b1;
    wire  [TIM_NUM-1:0] irq;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    apb_timer_array_if #(.APB_ADDR_WIDTH(12)) bus ();

    apb_timer_array #(
        .APB_ADDR_WIDTH(12),
        .TIM_NUM       (TIM_NUM),
        .CNT_WIDTH     (32),
        .PRESC_WIDTH   (8)
    ) dut (
        .pclk_i   (pclk),
        .presetn_i(presetn),
        .bus      (bus),
        .irq_o    (irq)
    );

    always #5 pclk = ~pclk;

    function automatic logic [11:0] addr(input int ch, input int rg);
        return 12'(ch * 16 + rg * 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge pclk);
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b1;
        bus.paddr_i   = a;
        bus.pwdata_i  = d;
        @(negedge pclk);
        bus.penable_i = 1'b1;
        @(posedge pclk);
        #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, input logic [31:0] exp,
                            input logic exp_err, input string tag);
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        e.tag  = tag;
        e.data = exp;
        e.err  = exp_err;
        sb.push_back(e);
        @(negedge pclk);
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.paddr_i   = a;
        @(negedge pclk);
        bus.penable_i = 1'b1;
        #2;
        rd = bus.prdata_o;
        er = bus.pslverr_o;
        @(posedge pclk);
        #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        e = sb.pop_front();
        check({e.tag, ".data"}, rd, e.data);
        check({e.tag, ".err"}, 32'(er), 32'(e.err));
    endtask

    task automatic tick_wait(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.paddr_i   = '0;
        bus.pwdata_i  = '0;

        // Reset state
        #1 presetn = 1'b0;
        #2;
        check("rst.irq", 32'(irq), 32'd0);
        check("rst.prdata", bus.prdata_o, 32'd0);
        check("rst.pslverr", 32'(bus.pslverr_o), 32'd0);
        check("rst.pready", 32'(bus.pready_o), 32'd1);
        #20 presetn = 1'b1;
        tick_wait(1);
        apb_read(addr(0, 2), 32'hFFFF_FFFF, 1'b0, "rst.ch0.cmp");
        apb_read(addr(2, 0), 32'h0, 1'b0, "rst.ch2.ctrl");

        // One-shot: ch0 PRESC=0 CMP=2
        apb_write(addr(0, 2), 32'd2);
        apb_write(addr(0, 0), 32'h3);
        tick_wait(4);
        apb_read(addr(0, 0), 32'h2, 1'b0, "os.ctrl");
        apb_read(addr(0, 3), 32'h1, 1'b0, "os.stat");
        apb_read(addr(0, 1), 32'h0, 1'b0, "os.cnt0");
        tick_wait(5);
        apb_read(addr(0, 1), 32'h0, 1'b0, "os.cnt1");
        check("os.irq0", 32'(irq[0]), 32'd0);

        // Periodic: ch1 PRESC=1 CMP=3 EN|IE; enabling write commits at edge E
        apb_write(addr(1, 2), 32'd3);
        apb_write(addr(1, 0), 32'h105);
        tick_wait(7);
        check("per.e7", 32'(irq[1]), 32'd0);
        tick_wait(1);
        check("per.e8", 32'(irq[1]), 32'd1);
        apb_write(addr(1, 3), 32'h1);
        check("per.clr1", 32'(irq[1]), 32'd0);
        tick_wait(5);
        check("per.e15", 32'(irq[1]), 32'd0);
        tick_wait(1);
        check("per.e16", 32'(irq[1]), 32'd1);
        apb_write(addr(1, 3), 32'h1);
        check("per.clr2", 32'(irq[1]), 32'd0);
        tick_wait(5);
        check("per.e23", 32'(irq[1]), 32'd0);
        tick_wait(1);
        check("per.e24", 32'(irq[1]), 32'd1);

        // W1C colliding with the match at E+32: set wins
        tick_wait(6);
        apb_write(addr(1, 3), 32'h1);
        check("coll.w1c.irq", 32'(irq[1]), 32'd1);
        apb_read(addr(1, 3), 32'h1, 1'b0, "coll.w1c.stat");

        // Asynchronous reset mid-run
        check("mid.pre.irq", 32'(irq[1]), 32'd1);
        #3 presetn = 1'b0;
        #1;
        check("mid.irq", 32'(irq), 32'd0);
        #10 presetn = 1'b1;
        tick_wait(1);
        for (int c = 0; c < TIM_NUM; c++) begin
            for (int r = 0; r < 4; r++) begin
                apb_read(addr(c, r), (r == 2) ? 32'hFFFF_FFFF : 32'h0, 1'b0,
                         $sformatf("mid.ch%0d.r%0d", c, r));
            end
        end

        // Decode: channel 3 does not exist
        apb_read(12'h030, 32'h0, 1'b1, "dec.rd30");
        apb_read(12'h03C, 32'h0, 1'b1, "dec.rd3c");
        apb_write(12'h038, 32'h0000_0055);
        apb_write(12'h030, 32'h0000_0007);
        apb_read(addr(0, 2), 32'hFFFF_FFFF, 1'b0, "dec.ch0.cmp");
        apb_read(addr(0, 0), 32'h0, 1'b0, "dec.ch0.ctrl");
        apb_read(12'h020, 32'h0, 1'b0, "dec.rd20");
        check("dec.irq", 32'(irq), 32'd0);

        // CNT write in a tick cycle: ch2 PRESC=3, first tick at E+4
        apb_write(addr(2, 0), 32'h301);
        tick_wait(2);
        apb_write(addr(2, 1), 32'h10);
        apb_read(addr(2, 1), 32'h10, 1'b0, "coll.cnt");
        tick_wait(4);
        apb_read(addr(2, 1), 32'h11, 1'b0, "coll.cnt.next");
        apb_write(addr(2, 0), 32'h0);

`ifdef APB_TIMER_CASCADE_EN
        // Cascade: ch0 CMP=1 PRESC=0 drives ch1 (CASC, CMP=2)
        apb_write(addr(0, 2), 32'd1);
        apb_write(addr(1, 2), 32'd2);
        apb_write(addr(1, 0), 32'hD);
        apb_read(addr(1, 0), 32'hD, 1'b0, "casc.ch1.ctrl");
        apb_write(addr(0, 0), 32'h9);
        tick_wait(5);
        check("casc.e5", 32'(irq[1]), 32'd0);
        tick_wait(1);
        check("casc.e6", 32'(irq[1]), 32'd1);
        apb_read(addr(0, 0), 32'h1, 1'b0, "casc.ch0.ctrl");
`else
        apb_write(addr(1, 0), 32'h8);
        apb_read(addr(1, 0), 32'h0, 1'b0, "nocasc.ch1.ctrl");
        apb_write(addr(1, 0), 32'hC);
        apb_read(addr(1, 0), 32'h4, 1'b0, "nocasc.ch1.ctrl2");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_timer_array.md
Name: apb_timer_array

Overview:
Parametrised multi-channel APB timer. It replaces the fixed two-IRQ-per-timer arrangement with TIM_NUM identical channels, each with its own prescaler, counter, compare value, mode and level interrupt. It sits on the peripheral APB bus as one slave. Channel selection is decoded from paddr_i inside the block.

Parameters:
APB_ADDR_WIDTH, 12, width of paddr_i
TIM_NUM, 4, number of timer channels (1..16, need not be a power of 2)
CNT_WIDTH, 32, counter and compare width (8..32); unused read bits return 0
PRESC_WIDTH, 8, prescaler width (1..16)

Ports:
pclk_i  input  1  APB clock, sole clock
presetn_i  input  1  asynchronous active-low reset
paddr_i  input  APB_ADDR_WIDTH  byte address
pwdata_i  input  32  write data
pwrite_i  input  1  write strobe
psel_i  input  1  slave select
penable_i  input  1  access phase
prdata_o  output  32  read data
pready_o  output  1  always 1 (zero wait state)
pslverr_o  output  1  error response
irq_o  output  TIM_NUM  per-channel level interrupt

Behaviour:
- Decode: register index = paddr_i[3:2]; channel = paddr_i[$clog2(TIM_NUM)+3:4] (1 bit when TIM_NUM=1).
- Channel >= TIM_NUM: pslverr_o=1 during access phase; writes ignored; prdata_o=0.
- Write commits on the cycle with psel_i & penable_i & pwrite_i. Read data is combinational from current register state.
- Registers per channel:
  - 0x0 CTRL: [0] EN; [1] ONESHOT; [2] IE; [3] CASC (see optional feature); [8+:PRESC_WIDTH] PRESC.
  - 0x4 CNT: R/W.
  - 0x8 CMP: R/W.
  - 0xC STAT: [0] MATCH, write-1-to-clear.
- Reset: all CTRL/CNT/STAT = 0, CMP = all ones, prescaler counters = 0, irq_o = 0, prdata_o = 0, pslverr_o = 0, pready_o = 1.
- Prescaler: while EN=1, pcnt increments each cycle. When pcnt == PRESC, tick=1 and pcnt returns to 0. PRESC=0 gives a tick every cycle; PRESC=N gives a tick every N+1 cycles. EN=0 holds pcnt at 0.
- On tick:
  - If CNT == CMP: CNT <= 0, MATCH <= 1; if ONESHOT, EN <= 0.
  - Otherwise CNT <= CNT+1, wrapping modulo 2^CNT_WIDTH (reached only if CMP is lowered below CNT by software).
- CMP=0 with PRESC=0: MATCH every tick, CNT stays 0.
- irq_o[i] = MATCH & IE, registered value, no extra latency beyond MATCH.
- Collisions:
  - APB write to CNT in the same cycle as a tick: the write wins and the tick is lost.
  - Write to CTRL in a tick cycle: CTRL takes the written value, including EN (overrides one-shot auto-clear).
  - W1C of MATCH in the same cycle a new match sets it: set wins.
  - Write to CTRL that changes EN 0->1: pcnt cleared, first tick after PRESC+1 cycles.
- Reset mid-count: all state returns to reset values immediately (asynchronous); no pending IRQ survives.

Optional Feature:
- Macro: APB_TIMER_CASCADE_EN.
- Defined: for channel i>0, CTRL[3] CASC=1 replaces channel i's prescaler tick with channel i-1's match event (same cycle as i-1's CNT reload). The channel must still have EN=1 to count. CASC is ignored for channel 0 and reads 0 there.
- Not defined: CTRL[3] reads 0 and writes to it are ignored; every channel uses its own prescaler.

Test Plan:
- Reset: assert presetn_i mid-run -> irq_o=0, CNT=0, CMP=0xFFFFFFFF, CTRL=0 read back on all channels.
- Periodic mode: ch1 PRESC=1, CMP=3, CTRL=EN|IE -> irq_o[1] rises 8 cycles after the enabling write; after a W1C clear, it rises again every 8 cycles.
- One-shot mode: ch0 PRESC=0, CMP=2, CTRL=EN|ONESHOT -> MATCH after 3 ticks, EN reads 0, CNT stays 0 thereafter.
- Decode with TIM_NUM=3: access at 0x30 (channel 3) -> pslverr_o=1, prdata_o=0, no state change; access at 0x20 -> pslverr_o=0.
- Collisions: W1C of STAT in a match cycle -> MATCH stays 1. CNT write of 0x10 in a tick cycle -> CNT reads 0x10 afterwards.
- Cascade (APB_TIMER_CASCADE_EN): ch0 CMP=1, PRESC=0; ch1 CASC=1, CMP=2 -> ch1 MATCH after 6 cycles. Without the macro, CASC reads 0.
